// File: rtl/sbio_rx_capture_if.sv
// sbio_rx_capture_if: result-record handshake between the rx capture stage and its consumer.
//   out_valid      head record present (driven by capture stage)
//   out_ready      consumer accepts the head this cycle
//   out_payload    head payload, LSB chunk first
//   out_timestamp  run-relative cycle of the head frame's start bit
`timescale 1ns/1ps
interface sbio_rx_capture_if #(
  parameter int unsigned RX_DATA_BITS  = 16,
  parameter int unsigned RX_DELAY_BITS = 16
);
  logic                     out_valid;
  logic                     out_ready;
  logic [RX_DATA_BITS-1:0]  out_payload;
  logic [RX_DELAY_BITS-1:0] out_timestamp;

  modport master (output out_valid, output out_payload, output out_timestamp, input out_ready);
  modport slave  (input out_valid, input out_payload, input out_timestamp, output out_ready);
endinterface

// File: rtl/sbio_rx_capture.sv
// sbio_rx_capture: detects start-bit framed transfers on the rx pin bus, deserialises the
// payload, stamps it with the run-relative cycle of its start bit and queues the record.
//   clk, reset   system clock, asynchronous active-high reset
//   run_mode     1 = capture and timestamp running, 0 = idle (timestamp held at 0)
//   rx_pins      synchronised rx pin bus, one IO_BITS chunk per cycle
//   rx_out       master side of the record handshake (valid/ready/payload/timestamp)
//   count        FIFO occupancy, 0..DEPTH
//   busy         a frame is being shifted in
//   overflow     sticky: a completed frame found the FIFO full and was dropped
`timescale 1ns/1ps
module sbio_rx_capture #(
  parameter int unsigned IO_BITS       = 2,
  parameter int unsigned RX_DATA_BITS  = 16,
  parameter int unsigned RX_DELAY_BITS = 16,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run_mode,
  input  logic [IO_BITS-1:0]       rx_pins,
  sbio_rx_capture_if.master        rx_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned BEATS = RX_DATA_BITS / IO_BITS;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam logic [RX_DELAY_BITS-1:0] TS_MAX    = '1;
  localparam logic [BW-1:0]            LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                   state, state_n;
  logic [BW-1:0]            beat, beat_n;
  logic [RX_DATA_BITS-1:0]  data, data_n;
  logic [RX_DELAY_BITS-1:0] frame_ts, frame_ts_n;
  logic [RX_DELAY_BITS-1:0] ts;
  logic                     push_c;

  logic [RX_DATA_BITS-1:0]  pay_mem [DEPTH];
  logic [RX_DELAY_BITS-1:0] ts_mem  [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count_n;
  logic                     pop_c, full_c, wr_c;
  logic                     run_q;

  // Run-relative timestamp, saturating instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts <= '0;
    end else if (!run_mode) begin
      ts <= '0;
    end else if (ts != TS_MAX) begin
      ts <= ts + RX_DELAY_BITS'(1);
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      beat     <= '0;
      data     <= '0;
      frame_ts <= '0;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      data     <= data_n;
      frame_ts <= frame_ts_n;
    end
  end

  // Frame FSM next state; the final chunk is merged into data_n so the record
  // is pushed on the same edge that samples the last beat
  always_comb begin
    state_n    = state;
    beat_n     = beat;
    data_n     = data;
    frame_ts_n = frame_ts;
    push_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_mode && rx_pins[0]) begin
          state_n    = S_SHIFT;
          beat_n     = '0;
          data_n     = '0;
          frame_ts_n = ts;
        end
      end
      S_SHIFT: begin
        if (!run_mode) begin
          state_n = S_IDLE;
          data_n  = '0;
        end else begin
          data_n[beat*IO_BITS +: IO_BITS] = rx_pins;
          beat_n = beat + BW'(1);
          if (beat == LAST_BEAT) begin
            push_c  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_SHIFT);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop_c   = rx_out.out_valid && rx_out.out_ready;
  assign full_c  = (count == CW'(DEPTH));
  assign wr_c    = push_c && (!full_c || pop_c);
  assign count_n = count + CW'(wr_c) - CW'(pop_c);

  // Record FIFO, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pay_mem[i] <= '0;
        ts_mem[i]  <= '0;
      end
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      rx_out.out_valid <= 1'b0;
      overflow         <= 1'b0;
      run_q            <= 1'b0;
    end else begin
      if (wr_c) begin
        pay_mem[wr_ptr] <= data_n;
        ts_mem[wr_ptr]  <= frame_ts;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count            <= count_n;
      rx_out.out_valid <= (count_n != '0);
      if (run_mode && !run_q) begin
        overflow <= 1'b0;
      end else if (push_c && !wr_c) begin
        overflow <= 1'b1;
      end
      run_q <= run_mode;
    end
  end

  assign rx_out.out_payload   = pay_mem[rd_ptr];
  assign rx_out.out_timestamp = ts_mem[rd_ptr];

endmodule

// File: tb/tb_sbio_rx_capture.sv
// tb_sbio_rx_capture: directed scenarios plus randomized traffic for sbio_rx_capture,
// checked every cycle against a queue-based frame/record reference model.
`timescale 1ns/1ps
module tb_sbio_rx_capture;

  localparam int unsigned IO    = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BEATS = DW / IO;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_mode = 1'b0;
  logic [1:0] rx_pins = 2'b00;
  logic [2:0] count, count_sat;
  logic       busy, busy_sat;
  logic       overflow, overflow_sat;

  sbio_rx_capture_if #(.RX_DATA_BITS(DW), .RX_DELAY_BITS(TW)) bus ();
  sbio_rx_capture_if #(.RX_DATA_BITS(DW), .RX_DELAY_BITS(4))  bus_sat ();

  sbio_rx_capture #(.IO_BITS(IO), .RX_DATA_BITS(DW), .RX_DELAY_BITS(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run_mode(run_mode), .rx_pins(rx_pins),
    .rx_out(bus.master), .count(count), .busy(busy), .overflow(overflow)
  );

  sbio_rx_capture #(.IO_BITS(IO), .RX_DATA_BITS(DW), .RX_DELAY_BITS(4), .DEPTH(DEPTH)) dut_sat (
    .clk(clk), .reset(reset), .run_mode(run_mode), .rx_pins(rx_pins),
    .rx_out(bus_sat.master), .count(count_sat), .busy(busy_sat), .overflow(overflow_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference model: frames as chunk accumulations, FIFO as queues
  int unsigned run_cycles;
  bit          prev_run, in_frame, m_ovf;
  int unsigned n_beats;
  logic [15:0] acc, fts;
  logic [15:0] mq_pay[$];
  logic [15:0] mq_ts[$];

  function automatic void model_reset();
    run_cycles = 0; prev_run = 0; in_frame = 0; m_ovf = 0;
    n_beats = 0; acc = '0; fts = '0;
    mq_pay.delete(); mq_ts.delete();
  endfunction

  function automatic void model_step(input bit rm, input logic [1:0] rx, input bit rdy);
    if (rdy && mq_pay.size() > 0) begin
      void'(mq_pay.pop_front());
      void'(mq_ts.pop_front());
    end
    if (rm && !prev_run) m_ovf = 0;
    if (in_frame) begin
      if (!rm) begin
        in_frame = 0;
      end else begin
        acc = acc | (16'(rx) << (IO * n_beats));
        n_beats++;
        if (n_beats == BEATS) begin
          in_frame = 0;
          if (mq_pay.size() < DEPTH) begin
            mq_pay.push_back(acc);
            mq_ts.push_back(fts);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end else if (rm && rx[0]) begin
      in_frame = 1;
      n_beats  = 0;
      acc      = '0;
      fts      = (run_cycles > 65535) ? 16'hFFFF : 16'(run_cycles);
    end
    run_cycles = rm ? run_cycles + 1 : 0;
    prev_run   = rm;
  endfunction

  task automatic check_all();
    check_eq("valid", {31'b0, bus.out_valid}, {31'b0, mq_pay.size() != 0});
    check_eq("count", {29'b0, count}, 32'(mq_pay.size()));
    check_eq("busy", {31'b0, busy}, {31'b0, in_frame});
    check_eq("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (mq_pay.size() != 0) begin
      check_eq("payload", {16'b0, bus.out_payload}, {16'b0, mq_pay[0]});
      check_eq("timestamp", {16'b0, bus.out_timestamp}, {16'b0, mq_ts[0]});
    end
  endtask

  // One clock cycle: inputs applied after a falling edge, outputs checked at the next one
  task automatic cycle(input bit rm, input logic [1:0] rx, input bit rdy);
    run_mode      = rm;
    rx_pins       = rx;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(rm, rx, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'b00, rdy);
  endtask

  task automatic send_frame(input logic [15:0] p, input bit rdy, input bit rdy_last);
    logic [15:0] pv;
    pv = p;
    cycle(1'b1, 2'b01, rdy);
    for (int k = 0; k < int'(BEATS); k++)
      cycle(1'b1, pv[2*k +: 2], (k == int'(BEATS) - 1) ? rdy_last : rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_count", {29'b0, count}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_overflow", {31'b0, overflow}, 32'd0);
    check_eq("rst_payload", {16'b0, bus.out_payload}, 32'd0);
    check_eq("rst_timestamp", {16'b0, bus.out_timestamp}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit rm, rdy;
    int unsigned rdy_bias;
    bus.out_ready     = 1'b0;
    bus_sat.out_ready = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Single frame: start at run cycle 10, payload 0xA5C3
    cycle(1'b0, 2'b00, 1'b0);
    idle(10, 1'b0);
    cycle(1'b1, 2'b01, 1'b0);
    begin
      logic [1:0] chunks [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
      for (int k = 0; k < 8; k++) cycle(1'b1, chunks[k], 1'b0);
    end
    check_eq("t1_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("t1_payload", {16'b0, bus.out_payload}, 32'hA5C3);
    check_eq("t1_timestamp", {16'b0, bus.out_timestamp}, 32'd10);
    check_eq("t1_count", {29'b0, count}, 32'd1);
    cycle(1'b1, 2'b00, 1'b1);
    check_eq("t1_pop_count", {29'b0, count}, 32'd0);
    check_eq("t1_pop_valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back frames at run cycles 5 and 14
    cycle(1'b0, 2'b00, 1'b0);
    idle(5, 1'b0);
    send_frame(16'h0001, 1'b0, 1'b0);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    check_eq("t2_count", {29'b0, count}, 32'd2);
    check_eq("t2_head_ts", {16'b0, bus.out_timestamp}, 32'd5);
    check_eq("t2_head_pay", {16'b0, bus.out_payload}, 32'h0001);
    cycle(1'b1, 2'b00, 1'b1);
    check_eq("t2_second_ts", {16'b0, bus.out_timestamp}, 32'd14);
    check_eq("t2_second_pay", {16'b0, bus.out_payload}, 32'hFFFF);
    cycle(1'b1, 2'b00, 1'b1);

    // Overflow: six frames into a 4-deep FIFO, then a push coinciding with a pop
    for (int i = 1; i <= 6; i++) send_frame(16'h1000 + 16'(i), 1'b0, 1'b0);
    check_eq("t3_count", {29'b0, count}, 32'd4);
    check_eq("t3_overflow", {31'b0, overflow}, 32'd1);
    check_eq("t3_head", {16'b0, bus.out_payload}, 32'h1001);
    send_frame(16'h1007, 1'b0, 1'b1);
    check_eq("t3_full_push_count", {29'b0, count}, 32'd4);
    check_eq("t3_new_head", {16'b0, bus.out_payload}, 32'h1002);
    cycle(1'b0, 2'b00, 1'b0);
    check_eq("t3_ovf_held_low_run", {31'b0, overflow}, 32'd1);
    cycle(1'b1, 2'b00, 1'b0);
    check_eq("t3_ovf_cleared", {31'b0, overflow}, 32'd0);
    idle(4, 1'b1);
    check_eq("t3_drained", {29'b0, count}, 32'd0);

    // Abort after beat 3, then pin activity with run_mode low
    cycle(1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'b11, 1'b0);
    check_eq("t4_busy_mid", {31'b0, busy}, 32'd1);
    cycle(1'b0, 2'b11, 1'b0);
    check_eq("t4_busy_abort", {31'b0, busy}, 32'd0);
    check_eq("t4_count", {29'b0, count}, 32'd0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'($urandom), 1'b0);
    check_eq("t4_idle_busy", {31'b0, busy}, 32'd0);
    idle(3, 1'b0);
    send_frame(16'hBEEF, 1'b0, 1'b0);
    check_eq("t4_resume_ts", {16'b0, bus.out_timestamp}, 32'd3);
    check_eq("t4_resume_pay", {16'b0, bus.out_payload}, 32'hBEEF);

    // Reset during beat 5 with two records queued
    send_frame(16'h2222, 1'b0, 1'b0);
    check_eq("t6_count_pre", {29'b0, count}, 32'd2);
    cycle(1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 2'b10, 1'b0);
    run_mode = 1'b1;
    rx_pins  = 2'b11;
    #2;
    do_reset();
    idle(2, 1'b0);
    send_frame(16'h5A5A, 1'b0, 1'b0);
    check_eq("t6_after_pay", {16'b0, bus.out_payload}, 32'h5A5A);
    check_eq("t6_after_ts", {16'b0, bus.out_timestamp}, 32'd2);

    // Timestamp saturation on the 4-bit-timestamp instance
    do_reset();
    idle(20, 1'b0);
    send_frame(16'h0F0F, 1'b0, 1'b0);
    check_eq("t5_main_ts", {16'b0, bus.out_timestamp}, 32'd20);
    check_eq("t5_sat_ts", {28'b0, bus_sat.out_timestamp}, 32'd15);
    check_eq("t5_sat_pay", {16'b0, bus_sat.out_payload}, 32'h0F0F);
    check_eq("t5_sat_count", {29'b0, count_sat}, 32'd1);
    check_eq("t5_sat_valid", {31'b0, bus_sat.out_valid}, 32'd1);
    check_eq("t5_sat_busy", {31'b0, busy_sat}, 32'd0);
    check_eq("t5_sat_ovf", {31'b0, overflow_sat}, 32'd0);

    // Randomized traffic: random pins, brief run_mode drops, bursty ready, rare resets
    rdy_bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) rdy_bias = $urandom_range(0, 4);
      rm  = ($urandom_range(0, 29) != 0);
      rdy = ($urandom_range(0, 3) < rdy_bias);
      cycle(rm, 2'($urandom), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sbio_rx_capture.md
Name: sbio_rx_capture

Overview:
Receive-side capture stage for the 2-bit serial bus I/O tester. Samples the IO_BITS-wide rx pin bus and detects frames that begin with a start bit. Deserialises each payload and timestamps it against a run-relative cycle counter. Queues the (payload, timestamp) records in a small FIFO, which the tester's result registers drain through a valid/ready handshake.

Parameters:
IO_BITS, 2, width of rx pin bus; one chunk per cycle
RX_DATA_BITS, 16, payload bits per frame; must be a multiple of IO_BITS
RX_DELAY_BITS, 16, timestamp width
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run_mode  in  1  1 = capture enabled and timestamp running; 0 = idle/clear
rx_pins  in  IO_BITS  sampled serial input (already synchronised upstream)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_payload  out  RX_DATA_BITS  head payload
out_timestamp  out  RX_DELAY_BITS  head start-bit timestamp
count  out  clog2(DEPTH)+1  FIFO occupancy
busy  out  1  frame being shifted in
overflow  out  1  sticky: a completed frame was dropped

Behaviour:
- Reset state: all outputs 0, FIFO empty, FSM in IDLE, ts = 0.
- Timestamp counter ts:
  - held at 0 while run_mode=0;
  - +1 per cycle while run_mode=1;
  - saturates at all-ones (no wrap).
- BEATS = RX_DATA_BITS/IO_BITS.
- FSM IDLE:
  - if run_mode=1 and rx_pins[0]=1 at cycle t, latch ts(t) as the frame timestamp, clear the beat counter, go to SHIFT;
  - all other rx_pins bits are ignored in that cycle.
- FSM SHIFT (busy=1):
  - on beat k (k = 0..BEATS-1), sampled at cycle t+1+k, write data[k*IO_BITS +: IO_BITS] = rx_pins; payload is LSB-chunk first;
  - after beat BEATS-1 (cycle t+BEATS), push the record and return to IDLE;
  - a start bit at cycle t+BEATS+1 is accepted, so back-to-back frames have no gap.
- Push latency: out_valid rises the cycle after the final beat when the FIFO was empty. No combinational path from rx_pins to the outputs.
- run_mode falling mid-frame: abort the frame, discard the partial payload, go to IDLE. FIFO contents are retained.
- FIFO:
  - pop when out_valid && out_ready;
  - out_payload/out_timestamp reflect the head entry and are stable while out_valid=1 and out_ready=0;
  - outputs are don't-care when empty.
- Full push:
  - if a pop happens in the same cycle, the push is accepted and count is unchanged;
  - otherwise the frame is dropped, count is unchanged, and overflow is set.
- Simultaneous push and pop on an empty FIFO: the pop is not possible (out_valid=0); the push proceeds normally.
- overflow clears only on reset or on a run_mode 0→1 edge. The FIFO is not flushed by run_mode edges.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Asynchronous reset mid-frame or mid-handshake: immediately returns to the reset state.

Test Plan:
1. Single frame, IO_BITS=2. run_mode rises at cycle 0; start bit at cycle 10; chunks 3,0,0,3,1,1,2,2 on cycles 11-18 -> out_valid=1 at cycle 19, out_payload=0xA5C3, out_timestamp=10, count=1. out_ready=1 -> count=0, out_valid=0 next cycle.
2. Back-to-back frames. Start bits at cycles 5 and 14, payloads 0x0001 and 0xFFFF, out_ready=0 -> count=2; heads pop in order with timestamps 5 and 14.
3. Overflow. Six frames with out_ready=0 -> count=4, overflow=1, and the first four payloads are retained. A later frame with out_ready=1 during its push cycle is accepted and count stays 4. A run_mode 0→1 toggle clears overflow.
4. Abort. run_mode drops after beat 3 -> busy=0 next cycle, count unchanged. rx_pins activity while run_mode=0 is ignored and ts=0.
5. Saturation. With RX_DELAY_BITS=4, a start bit at cycle 20 after run start -> out_timestamp=15.
6. Reset. Assert reset during beat 5 with count=2 -> all outputs 0 immediately; the next frame after release captures correctly.
